// File: rtl/nexys_starship_repair_ctrl.sv
// Repair-code controller for the four ship rooms. It issues an LFSR code when a room
// breaks, checks player submissions, and raises game over on timeout or too many strikes.
module nexys_starship_repair_ctrl #(
  parameter int TIMER_W        = 30,
  parameter int TIMEOUT_CYCLES = 1000000000,
  parameter int MAX_STRIKES    = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        play_flag,
  input  logic [3:0]  broken,
  input  logic        submit,
  input  logic [3:0]  submit_value,
  input  logic [1:0]  room_sel,
  output logic [15:0] combo,
  output logic [3:0]  armed,
  output logic [3:0]  repair_done,
  output logic        fail_pulse,
  output logic [1:0]  strikes,
  output logic        game_over_req
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ARMED = 1'b1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [1:0]         STRIKE_MAX = 2'(MAX_STRIKES);

  logic [15:0]        r_lfsr;
  logic [3:0]         r_brk_q;
  logic [3:0]         r_state;
  logic [15:0]        r_code;
  logic [TIMER_W-1:0] r_timer [4];
  logic [3:0]         r_done;
  logic               r_fail;
  logic [1:0]         r_strikes;
  logic               r_gover;

  logic        w_fb;
  logic [3:0]  w_rise;
  logic [15:0] w_cand;
  logic [3:0]  w_hit;
  logic [3:0]  w_ok;
  logic [3:0]  w_tmo;
  logic        w_bad;
  logic [1:0]  w_strikes_nxt;
  logic        w_gover_set;

  assign w_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_rise = broken & ~r_brk_q;

  // Zero nibbles become 1 so an idle switch bank never matches a fresh code.
  always_comb begin
    w_cand = r_lfsr;
    w_hit  = '0;
    w_ok   = '0;
    w_tmo  = '0;
    for (int r = 0; r < 4; r++) begin
      if (r_lfsr[4*r +: 4] == 4'h0) w_cand[4*r +: 4] = 4'h1;
      w_hit[r] = submit && (room_sel == 2'(r)) && (r_state[r] == ST_ARMED);
      w_ok[r]  = (submit_value == r_code[4*r +: 4]);
      w_tmo[r] = (r_state[r] == ST_ARMED) && !w_hit[r] && (r_timer[r] == TIMER_W'(1));
    end
  end

  assign w_bad         = play_flag && |(w_hit & ~w_ok);
  assign w_strikes_nxt = (r_strikes == STRIKE_MAX) ? r_strikes : r_strikes + 2'd1;
  assign w_gover_set   = (play_flag && |w_tmo) || (w_bad && w_strikes_nxt == STRIKE_MAX);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_lfsr    <= 16'hACE1;
      r_brk_q   <= '0;
      r_state   <= '0;
      r_code    <= '0;
      r_done    <= '0;
      r_fail    <= 1'b0;
      r_strikes <= '0;
      r_gover   <= 1'b0;
      for (int r = 0; r < 4; r++) r_timer[r] <= '0;
    end else begin
      r_lfsr  <= {w_fb, r_lfsr[15:1]};
      r_brk_q <= broken;
      r_done  <= '0;
      r_fail  <= 1'b0;
      if (!play_flag) begin
        r_state   <= '0;
        r_code    <= '0;
        r_strikes <= '0;
        for (int r = 0; r < 4; r++) r_timer[r] <= '0;
      end else begin
        for (int r = 0; r < 4; r++) begin
          if (r_state[r] == ST_IDLE) begin
            if (w_rise[r]) begin
              r_state[r]       <= ST_ARMED;
              r_code[4*r +: 4] <= w_cand[4*r +: 4];
              r_timer[r]       <= TIMER_LOAD;
            end
          end else if (w_hit[r] && w_ok[r]) begin
            r_state[r]       <= ST_IDLE;
            r_code[4*r +: 4] <= 4'h0;
            r_timer[r]       <= '0;
            r_done[r]        <= 1'b1;
          end else if (!w_hit[r] && r_timer[r] != '0) begin
            r_timer[r] <= r_timer[r] - TIMER_W'(1);
          end
        end
        if (w_bad) begin
          r_fail    <= 1'b1;
          r_strikes <= w_strikes_nxt;
        end
      end
      if (w_gover_set) r_gover <= 1'b1;
    end
  end

  assign combo         = r_code;
  assign armed         = r_state;
  assign repair_done   = r_done;
  assign fail_pulse    = r_fail;
  assign strikes       = r_strikes;
  assign game_over_req = r_gover;

endmodule

// File: tb/tb_nexys_starship_repair_ctrl.sv
// Bench for nexys_starship_repair_ctrl: directed scenarios plus random traffic,
// all checked against a rule-level model of rooms, codes, timers and strikes.
module tb_nexys_starship_repair_ctrl;

  localparam int TMO = 8;
  localparam int MAXS = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        play_flag = 1'b1;
  logic [3:0]  broken = 4'b1111;
  logic        submit = 1'b0;
  logic [3:0]  submit_value = 4'h0;
  logic [1:0]  room_sel = 2'd0;
  logic [15:0] combo;
  logic [3:0]  armed;
  logic [3:0]  repair_done;
  logic        fail_pulse;
  logic [1:0]  strikes;
  logic        game_over_req;

  nexys_starship_repair_ctrl #(
    .TIMER_W(30), .TIMEOUT_CYCLES(TMO), .MAX_STRIKES(MAXS)
  ) dut (
    .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .broken(broken),
    .submit(submit), .submit_value(submit_value), .room_sel(room_sel),
    .combo(combo), .armed(armed), .repair_done(repair_done),
    .fail_pulse(fail_pulse), .strikes(strikes), .game_over_req(game_over_req)
  );

  always #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int m_lfsr;
  int m_brkq;
  bit m_arm [4];
  int m_code [4];
  int m_timer [4];
  int m_done;
  bit m_fail;
  int m_strikes;
  bit m_gover;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr = 16'hACE1; m_brkq = 0; m_done = 0; m_fail = 0; m_strikes = 0; m_gover = 0;
    for (int r = 0; r < 4; r++) begin m_arm[r] = 0; m_code[r] = 0; m_timer[r] = 0; end
  endtask

  task automatic model_step();
    int cur, rise, bit_in;
    if (Reset) begin model_reset(); return; end
    cur    = m_lfsr;
    bit_in = ((cur >> 0) ^ (cur >> 2) ^ (cur >> 3) ^ (cur >> 5)) & 1;
    m_lfsr = (cur >> 1) | (bit_in << 15);
    rise   = int'(broken) & ~m_brkq & 15;
    m_brkq = int'(broken);
    m_done = 0;
    m_fail = 0;
    if (!play_flag) begin
      m_strikes = 0;
      for (int r = 0; r < 4; r++) begin m_arm[r] = 0; m_code[r] = 0; m_timer[r] = 0; end
      return;
    end
    for (int r = 0; r < 4; r++) begin
      if (!m_arm[r]) begin
        if ((rise >> r) & 1) begin
          m_arm[r]   = 1;
          m_code[r]  = (cur >> (4 * r)) & 15;
          if (m_code[r] == 0) m_code[r] = 1;
          m_timer[r] = TMO;
        end
      end else if (submit && int'(room_sel) == r) begin
        if (int'(submit_value) == m_code[r]) begin
          m_arm[r] = 0; m_code[r] = 0; m_timer[r] = 0;
          m_done |= (1 << r);
        end else begin
          m_fail = 1;
          if (m_strikes < MAXS) m_strikes++;
          if (m_strikes == MAXS) m_gover = 1;
        end
      end else if (m_timer[r] > 0) begin
        m_timer[r]--;
        if (m_timer[r] == 0) m_gover = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int e_combo, e_armed;
    e_combo = 0; e_armed = 0;
    for (int r = 0; r < 4; r++) begin
      e_combo |= (m_code[r] << (4 * r));
      e_armed |= (int'(m_arm[r]) << r);
    end
    chk({tag, ".combo"}, 32'(combo), 32'(e_combo));
    chk({tag, ".armed"}, 32'(armed), 32'(e_armed));
    chk({tag, ".done"}, 32'(repair_done), 32'(m_done));
    chk({tag, ".fail"}, 32'(fail_pulse), 32'(m_fail));
    chk({tag, ".strikes"}, 32'(strikes), 32'(m_strikes));
    chk({tag, ".gover"}, 32'(game_over_req), 32'(m_gover));
  endtask

  task automatic tick(input string tag);
    @(posedge Clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick("rst");
    tick("rst");
    Reset = 1'b0;
  endtask

  initial begin
    model_reset();
    // Test 1: rooms broken and play high through reset release
    tick("t1rst");
    tick("t1rst");
    chk("t1_reset_combo", 32'(combo), 32'h0);
    Reset = 1'b0;
    tick("t1");
    chk("t1_armed", 32'(armed), 32'hF);
    chk("t1_combo", 32'(combo), 32'hACE1);

    // Test 2: correct code for room 0, broken stays high
    submit = 1'b1; room_sel = 2'd0; submit_value = 4'h1;
    tick("t2");
    chk("t2_done", 32'(repair_done), 32'h1);
    chk("t2_nib0", 32'(combo[3:0]), 32'h0);
    submit = 1'b0;
    tick("t2b");
    chk("t2_done_one_cycle", 32'(repair_done), 32'h0);
    tick("t2c");
    chk("t2_no_rearm", 32'(armed[0]), 32'h0);

    // Test 3: wrong codes for room 2 (code C)
    room_sel = 2'd2; submit_value = 4'h3;
    for (int k = 1; k <= 4; k++) begin
      submit = 1'b1;
      tick("t3");
      chk("t3_fail", 32'(fail_pulse), 32'h1);
      chk("t3_strikes", 32'(strikes), 32'((k > 3) ? 3 : k));
      if (k >= 3) chk("t3_gover", 32'(game_over_req), 32'h1);
      else        chk("t3_no_gover", 32'(game_over_req), 32'h0);
    end
    submit = 1'b0;

    // Test 4: timeout on room 1, then correct submit on the expiring cycle
    broken = 4'b0000;
    do_reset();
    tick("t4idle");
    broken = 4'b0010;
    tick("t4arm");
    chk("t4_armed", 32'(armed), 32'h2);
    for (int k = 1; k <= TMO; k++) begin
      tick("t4cnt");
      chk("t4_gover_timing", 32'(game_over_req), 32'(k == TMO));
    end
    broken = 4'b0000;
    do_reset();
    tick("t4idle2");
    broken = 4'b0010;
    tick("t4arm2");
    for (int k = 1; k < TMO; k++) tick("t4cnt2");
    submit = 1'b1; room_sel = 2'd1; submit_value = 4'(m_code[1]);
    tick("t4race");
    chk("t4_race_done", 32'(repair_done), 32'h2);
    chk("t4_race_gover", 32'(game_over_req), 32'h0);
    submit = 1'b0;

    // Test 5: submit to idle room ignored; play_flag drop clears rooms
    submit = 1'b1; room_sel = 2'd3; submit_value = 4'h5;
    tick("t5idle");
    chk("t5_no_fail", 32'(fail_pulse), 32'h0);
    chk("t5_no_strike", 32'(strikes), 32'h0);
    submit = 1'b0;
    broken = 4'b1111;
    tick("t5arm");
    chk("t5_armed", 32'(armed), 32'hD);
    submit = 1'b1; room_sel = 2'd0; submit_value = 4'(m_code[0] ^ 1);
    tick("t5wrong");
    chk("t5_strike", 32'(strikes), 32'h1);
    submit = 1'b0; play_flag = 1'b0;
    tick("t5drop");
    chk("t5_drop_armed", 32'(armed), 32'h0);
    chk("t5_drop_combo", 32'(combo), 32'h0);
    chk("t5_drop_strikes", 32'(strikes), 32'h0);
    play_flag = 1'b1;

    // Test 6: asynchronous reset mid-countdown after game over
    broken = 4'b0000;
    tick("t6idle");
    broken = 4'b0001;
    tick("t6arm");
    for (int k = 0; k < TMO; k++) tick("t6cnt");
    chk("t6_gover_before", 32'(game_over_req), 32'h1);
    broken = 4'b1111;
    #3 Reset = 1'b1;
    #1;
    model_reset();
    chk("t6_async_combo", 32'(combo), 32'h0);
    chk("t6_async_armed", 32'(armed), 32'h0);
    chk("t6_async_gover", 32'(game_over_req), 32'h0);
    chk("t6_async_strikes", 32'(strikes), 32'h0);
    tick("t6rst");
    Reset = 1'b0;
    tick("t6rel");
    chk("t6_lfsr_restart", 32'(combo), 32'hACE1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      Reset     = ($urandom_range(0, 79) == 0);
      play_flag = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 3) == 0) broken[$urandom_range(0, 3)] ^= 1'b1;
      submit   = ($urandom_range(0, 2) == 0);
      room_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) submit_value = 4'(m_code[room_sel]);
      else                           submit_value = 4'($urandom_range(0, 15));
      tick("rnd");
    end
    Reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
